// File: rtl/ram_loader.sv
// Sequential write master for the ram: takes a valid/ready byte stream and writes it
// to consecutive addresses with one setup and one hold cycle around every write strobe.
module ram_loader #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] mem_address,
    inout  wire  [DATA_BITS-1:0] mem_data,
    output logic                 mem_out_en,
    output logic                 mem_write_en
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_SETUP  = 3'd2,
        S_WRITE  = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0]   CNT_ZERO  = (ADDR_BITS + 1)'(0);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [ADDR_BITS:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;

    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   write_en_q, write_en_d;
    logic                   drive_q, drive_d;
    logic [ADDR_BITS-1:0]   mem_address_q, mem_address_d;

    logic                   accept_s;

    // in_ready_q is high exactly while in ACCEPT, so this is the stream handshake
    assign accept_s = in_valid & in_ready_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == CNT_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (accept_s) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_SETUP: state_d = S_WRITE;
            S_WRITE: state_d = S_HOLD;
            S_HOLD: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop
    always_comb begin
        in_ready_d    = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        write_en_d    = 1'b0;
        drive_d       = 1'b0;
        mem_address_d = mem_address_q;
        case (state_d)
            S_ACCEPT: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_SETUP: begin
                busy_d        = 1'b1;
                drive_d       = 1'b1;
                mem_address_d = addr_q;
            end
            S_WRITE: begin
                busy_d     = 1'b1;
                drive_d    = 1'b1;
                write_en_d = 1'b1;
            end
            S_HOLD: begin
                busy_d  = 1'b1;
                drive_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            write_en_q    <= 1'b0;
            drive_q       <= 1'b0;
            mem_address_q <= {ADDR_BITS{1'b0}};
        end else begin
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            write_en_q    <= write_en_d;
            drive_q       <= drive_d;
            mem_address_q <= mem_address_d;
        end
    end

    // Datapath next-state: address/count captured at start, byte captured on handshake
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        case (state_q)
            S_IDLE: begin
                if (start && (length != CNT_ZERO)) begin
                    addr_d = base_addr;
                    cnt_d  = length;
                end else begin
                    addr_d = addr_q;
                    cnt_d  = cnt_q;
                end
            end
            S_ACCEPT: begin
                if (accept_s) begin
                    data_d = in_data;
                end else begin
                    data_d = data_q;
                end
            end
            S_HOLD: begin
                // address wraps naturally at 2^ADDR_BITS
                addr_d = addr_q + ADDR_ONE;
                cnt_d  = cnt_q - CNT_ONE;
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= {ADDR_BITS{1'b0}};
            cnt_q  <= {(ADDR_BITS + 1){1'b0}};
            data_q <= {DATA_BITS{1'b0}};
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_write_en = write_en_q;
    assign mem_address  = mem_address_q;
    // The loader never reads, so the ram can never drive the bus against us
    assign mem_out_en   = 1'b0;
    assign mem_data     = drive_q ? data_q : {DATA_BITS{1'bz}};

endmodule

// File: tb/tb_ram_loader.sv
// Randomized scoreboard bench for ram_loader: a ram model captures writes, expected
// writes/done pulses are queued by the stimulus and checked by an independent monitor.
module tb_ram_loader;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [3:0] mem_address;
    tri1  [7:0] mem_data;
    logic       mem_out_en;
    logic       mem_write_en;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] ram     [16];
    logic [7:0] ref_mem [16];
    wr_t        exp_q[$];
    int         done_q[$];
    logic [7:0] tab[$];

    ram_loader #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done), .mem_address(mem_address), .mem_data(mem_data),
        .mem_out_en(mem_out_en), .mem_write_en(mem_write_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Ram model: write-only view of the ram this loader feeds
    always @(posedge clk) begin
        if (mem_write_en && !mem_out_en) ram[mem_address] <= mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expected writes/done pulses whenever the DUT presents one
    initial begin
        logic       prev_we = 1'b0;
        logic [3:0] prev_addr = 4'd0;
        logic [7:0] prev_bus = 8'hFF;
        bit         hold_pend = 1'b0;
        wr_t        hold_e;
        wr_t        e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("out_en_low", {31'd0, mem_out_en}, 32'd0);
                if (hold_pend) begin
                    check("hold_we_low", {31'd0, mem_write_en}, 32'd0);
                    check("hold_addr", {28'd0, mem_address}, hold_e.addr);
                    check("hold_data", {24'd0, mem_data}, {24'd0, hold_e.data});
                    hold_pend = 1'b0;
                end
                if (mem_write_en) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", {28'd0, mem_address}, e.addr);
                        check("write_data", {24'd0, mem_data}, {24'd0, e.data});
                        check("write_cycle", cyc, e.cyc);
                        check("setup_we_low", {31'd0, prev_we}, 32'd0);
                        check("setup_addr", {28'd0, prev_addr}, e.addr);
                        check("setup_data", {24'd0, prev_bus}, {24'd0, e.data});
                        hold_e = e;
                        hold_pend = 1'b1;
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        check("done_cycle", cyc, done_q.pop_front());
                        check("done_busy_low", {31'd0, busy}, 32'd0);
                    end
                end
            end else begin
                hold_pend = 1'b0;
            end
            prev_we   = mem_write_en;
            prev_addr = mem_address;
            prev_bus  = mem_data;
        end
    end

    task automatic check_ram();
        for (int a = 0; a < 16; a++) check($sformatf("ram[%0d]", a), {24'd0, ram[a]}, {24'd0, ref_mem[a]});
    endtask

    // One load: bytes come from tab (or are random); gap cycles of idle stream before each byte
    task automatic run_load(input int base, input int len, input int gap, input bit b2b,
                            input int inject_at, input int abort_at);
        int c;
        int waits;
        int addr;
        logic [7:0] d;
        @(negedge clk);
        start = 1'b1;
        base_addr = base[3:0];
        length = len[4:0];
        c = cyc;
        if (len == 0) done_q.push_back(c + 1);
        @(negedge clk);
        start = 1'b0;
        if (len == 0) begin
            for (int k = 0; k < 3; k++) begin
                check("len0_busy", {31'd0, busy}, 32'd0);
                check("len0_we", {31'd0, mem_write_en}, 32'd0);
                check("len0_bus", {24'd0, mem_data}, 32'hFF);
                @(negedge clk);
            end
            return;
        end
        for (int i = 0; i < len; i++) begin
            addr = (base + i) % 16;
            d = (tab.size() > 0) ? tab.pop_front() : 8'($urandom_range(254, 0));
            waits = 0;
            if (b2b) begin
                in_valid = 1'b1;
                in_data = d;
                while (!in_ready && waits < 40) begin
                    @(negedge clk);
                    waits++;
                end
                if (waits < 40) check("b2b_ready_wait", waits, (i == 0) ? 0 : 3);
            end else begin
                in_valid = 1'b0;
                while (!in_ready && waits < 40) begin
                    @(negedge clk);
                    waits++;
                end
                for (int j = 0; j < gap && waits < 40; j++) begin
                    check("gap_ready", {31'd0, in_ready}, 32'd1);
                    check("gap_busy", {31'd0, busy}, 32'd1);
                    check("gap_we", {31'd0, mem_write_en}, 32'd0);
                    check("gap_bus_z", {24'd0, mem_data}, 32'hFF);
                    start = (i == inject_at && j == 0);
                    base_addr = 4'd9;
                    length = 5'd2;
                    @(negedge clk);
                end
                start = 1'b0;
                in_valid = 1'b1;
                in_data = d;
            end
            if (waits >= 40 || !in_ready) begin
                fail_now("handshake_timeout");
                in_valid = 1'b0;
                return;
            end
            c = cyc;
            if (i == abort_at) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                check("abort_in_write", {31'd0, mem_write_en}, 32'd1);
                #1;
                in_valid = 1'b0;
                reset_n = 1'b0;
                #1;
                check("rst_we", {31'd0, mem_write_en}, 32'd0);
                check("rst_ready", {31'd0, in_ready}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_bus_z", {24'd0, mem_data}, 32'hFF);
                check("rst_addr", {28'd0, mem_address}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                repeat (2) @(negedge clk);
                check("post_rst_idle", {31'd0, busy}, 32'd0);
                return;
            end
            exp_q.push_back('{addr: addr, data: d, cyc: c + 2});
            ref_mem[addr] = d;
            if (i == len - 1) done_q.push_back(c + 4);
            @(negedge clk);
            if (!b2b || i == len - 1) in_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        check("done_drained", done_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 16; a++) begin
            ram[a] = 8'h00;
            ref_mem[a] = 8'h00;
        end
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = 4'd0;
        length = 5'd0;
        in_data = 8'd0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, in_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_addr", {28'd0, mem_address}, 32'd0);
        check("reset_we", {31'd0, mem_write_en}, 32'd0);
        check("reset_oe", {31'd0, mem_out_en}, 32'd0);
        check("reset_bus_z", {24'd0, mem_data}, 32'hFF);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        tab = '{8'h00, 8'h01, 8'h02};
        run_load(0, 3, 0, 1'b1, -1, -1);
        check_ram();
        tab = '{8'hA5, 8'h3C};
        run_load(5, 2, 6, 1'b0, -1, -1);
        check_ram();
        tab = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(14, 4, 1, 1'b0, -1, -1);
        check_ram();
        run_load(7, 0, 0, 1'b0, -1, -1);
        check_ram();
        run_load(2, 3, 3, 1'b0, 1, -1);
        check_ram();
        tab = '{8'h5E, 8'h6F, 8'h70};
        run_load(0, 3, 0, 1'b1, -1, 1);
        tab.delete();
        check_ram();
        run_load(10, 2, 0, 1'b1, -1, -1);
        check_ram();
        for (int k = 0; k < 8; k++) begin
            run_load($urandom_range(15, 0), $urandom_range(16, 1), $urandom_range(3, 0),
                     1'($urandom_range(1, 0)), -1, -1);
            check_ram();
        end
        run_load(3, 16, 0, 1'b1, -1, -1);
        check_ram();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
